clk_div_bank: RTL

- Bank of NCH independent, runtime-programmable integer clock dividers sharing one clock.
- Each channel produces:
  - a one-cycle tick (clock-enable pulse, as used by the existing divide-by-6 enable);
  - optionally a near-50% square output.
- Divisors and modes load through a valid/ready config port and take effect glitch-free at the channel's next period boundary.
- Sits next to the system clock root; feeds slow-rate enables to downstream blocks.

---
 rtl/clk_div_bank.sv | 126 ++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Bank of runtime-programmable integer dividers producing tick
//            enables and optional near-50% square outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 6,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic             cfg_err,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] C_MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);
  localparam logic [CH_W:0]    C_NCH     = (CH_W+1)'(NCH);

  logic [NCH-1:0] w_pending;
  logic           w_ch_ok;
  logic           w_bad;
  logic           w_accept;
  logic           r_err;

  // Out-of-range channels never stall the port; they are rejected instead.
  assign w_ch_ok   = ({1'b0, cfg_ch} < C_NCH);
  assign cfg_ready = w_ch_ok ? ~w_pending[cfg_ch] : 1'b1;
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_bad     = ~w_ch_ok | (cfg_div < C_MIN_DIV);
  assign cfg_err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_sdiv;
    logic [DIV_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_smode;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk;
    logic             w_wr;
    logic             w_wrap;
    logic             w_bound;
    logic             w_mode_n;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_cnt_inc;

    assign w_wr      = w_accept & ~w_bad & (cfg_ch == CH_W'(i));
    assign w_wrap    = (r_cnt == (r_div - C_ONE));
    assign w_bound   = ~en[i] | sync | w_wrap;
    assign w_mode_n  = r_pend ? r_smode : r_mode;
    assign w_half    = r_div - (r_div >> 1);
    assign w_cnt_inc = r_cnt + C_ONE;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_div   <= C_DEF_DIV;
        r_mode  <= 1'b0;
        r_sdiv  <= C_DEF_DIV;
        r_smode <= 1'b0;
        r_pend  <= 1'b0;
        r_cnt   <= '0;
        r_tick  <= 1'b0;
        r_clk   <= 1'b0;
      end else begin
        if (w_bound && r_pend) begin
          r_div  <= r_sdiv;
          r_mode <= r_smode;
          r_pend <= 1'b0;
        end
        // A write is only accepted while nothing is pending, so it never
        // collides with the apply above and waits for the next boundary.
        if (w_wr) begin
          r_sdiv  <= cfg_div;
          r_smode <= cfg_mode;
          r_pend  <= 1'b1;
        end
        if (!en[i]) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_clk  <= 1'b0;
        end else if (sync) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_clk  <= w_mode_n;
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_clk  <= w_mode_n;
        end else begin
          r_cnt  <= w_cnt_inc;
          r_tick <= 1'b0;
          r_clk  <= r_mode & (w_cnt_inc < w_half);
        end
      end
    end

    assign w_pending[i] = r_pend;
    assign tick[i]      = r_tick;
    assign clk_out[i]   = r_clk;
  end

endmodule
`default_nettype wire
